conv_lut_bitsel_pipe: RTL and testbench
=======================================

// Module: conv_lut_bitsel_pipe
// PURPOSE
// - Programmable multi-channel bit-code lookup for the conv datapath. Each of CH lanes maps an
//   IN_W-bit code to an OUT_W-bit code through one shared table.
// - Table resets to a window-extract map: out = in[SHIFT+OUT_W-1:SHIFT].
// - Table is rewritable at run time and can be restored to its default.
// - Sits between the activation quantiser and the conv MAC array.
// - Two-stage valid/ready pipeline with full throughput.
// PARAMETERS
// - IN_W   4  input code width per lane; table depth = 2**IN_W
// - OUT_W  2  output code width per lane
// - SHIFT  1  LSB position of default extract window; SHIFT+OUT_W <= IN_W
// - CH     4  number of parallel lanes
// PORTS
// - clk          in   1         single clock, rising edge
// - rst_n        in   1         asynchronous active-low reset
// - cfg_we       in   1         table write strobe
// - cfg_addr     in   IN_W      table write address
// - cfg_data     in   OUT_W     table write data
// - cfg_restore  in   1         pulse: reload default table
// - busy         out  1         high in DRAIN/RESTORE
// - in_valid     in   1         input beat valid
// - in_ready     out  1         input beat accepted when valid&ready
// - in_data      in   CH*IN_W   lane k = in_data[k*IN_W +: IN_W]
// - out_valid    out  1         output beat valid
// - out_ready    in   1         downstream accept
// - out_data     out  CH*OUT_W  lane k = out_data[k*OUT_W +: OUT_W]
// BEHAVIOUR
// - Reset (async): all table entries = default(i); FSM=IDLE.
//   Outputs: s1/s2 valids 0, out_valid=0, out_data=0, busy=0, in_ready=0 while rst_n low.
// - Pipeline:
//   - adv = !out_valid | out_ready.
//   - S1 captures in_data/in_valid when adv.
//   - S2 captures LUT[s1 lane code] per lane, plus s1_valid, when adv.
//   - in_ready = adv & (state==IDLE).
//   - Latency 2 cycles accept->out_valid; 1 beat/cycle when out_ready held high.
//   - out_data holds stable while out_valid & !out_ready.
// - Table write:
//   - cfg_we in IDLE writes LUT[cfg_addr] <= cfg_data at the edge.
//   - A lookup of the same address on the same edge reads the OLD value; new value from next cycle.
//   - cfg_we in DRAIN/RESTORE is ignored (dropped).
// - FSM:
//   - IDLE -> DRAIN on cfg_restore. If cfg_we is also high that cycle, the write still happens first.
//   - DRAIN: no new input; wait until s1_valid=0 and s2_valid=0. In-flight beats complete using the
//     pre-restore table.
//   - RESTORE: 4-bit+ counter addr 0..2**IN_W-1, one entry per cycle, LUT[addr] <= default(addr);
//     -> IDLE after the last entry. Duration exactly 2**IN_W cycles.
//   - cfg_restore during DRAIN/RESTORE is ignored (no restart).
//   - Reset mid-DRAIN/RESTORE: full async default load, FSM=IDLE, pipeline flushed.
// - default(i): (i >> SHIFT) & (2**OUT_W-1), truncating; modified by the macro below.
// CONFIGURATION
// - CONV_LUT_SAT_EN defined: default(i) saturates, i.e. all-ones OUT_W when any bit of i above
//   SHIFT+OUT_W-1 is set, else the window extract.
//   Applies to both the reset load and RESTORE.
// - Undefined: plain truncating window extract.
// - Written entries are unaffected either way.
// TESTING (IN_W=4, OUT_W=2, SHIFT=1, CH=4)
// - Default map: lanes in 4'b0110,4'b0011,4'b0100,4'b0001 -> out lanes 2'b11,2'b01,2'b10,2'b00
//   two cycles later; sweep all 16 codes.
// - Saturation: in 4'b1010 -> 2'b01 without CONV_LUT_SAT_EN; -> 2'b11 with it.
//   In 4'b0100 -> 2'b10 in both builds.
// - Backpressure: stream 8 beats, out_ready=0 for 3 cycles mid-stream.
//   -> no loss or duplication; out_data stable while stalled; in_ready=0 while S2 full & stalled.
// - Write collision: cfg_we addr=6 data=2'b00 on the same edge S1 holds code 6 -> that beat out 2'b11;
//   next code-6 beat -> 2'b00.
// - Restore: write addr 3 <= 2'b10, pulse cfg_restore with 2 beats in flight.
//   -> both beats complete; busy high; in_ready low for drain + 16 cycles; code 3 then -> 2'b01.
// - Async reset asserted mid-RESTORE (addr=7): out_valid=0 immediately; after release all 16
//   entries = default; busy=0.

Source files
------------

// File: rtl/conv_lut_bitsel_pipe.sv
// Per-lane code remap via one shared rewritable LUT (default = window extract, saturating under CONV_LUT_SAT_EN).
// Latency 2 cycles accept->out_valid, full throughput; out_ready low stalls both stages and drops in_ready.
module conv_lut_bitsel_pipe #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2,
  parameter int SHIFT = 1,
  parameter int CH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [IN_W-1:0]     cfg_addr,
  input  logic [OUT_W-1:0]    cfg_data,
  input  logic                cfg_restore,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*IN_W-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*OUT_W-1:0] out_data
);
  localparam int DEPTH = 2**IN_W;

  typedef enum logic [1:0] {IDLE, DRAIN, RESTORE} state_t;

  state_t              state_q, state_d;
  logic [IN_W-1:0]     rcnt_q, rcnt_d;
  logic [OUT_W-1:0]    lut_q [DEPTH];
  logic                s1_vld_q;
  logic [CH*IN_W-1:0]  s1_dat_q;
  logic                s2_vld_q;
  logic [CH*OUT_W-1:0] s2_dat_q, s2_dat_d;
  logic                adv;
  logic                lut_we;
  logic [IN_W-1:0]     lut_waddr;
  logic [OUT_W-1:0]    lut_wdat;

  function automatic logic [OUT_W-1:0] def_val(input logic [IN_W-1:0] i);
    logic [IN_W-1:0] sh;
    sh = i >> SHIFT;
`ifdef CONV_LUT_SAT_EN
    if ((i >> (SHIFT + OUT_W)) != '0) return '1;
`endif
    return sh[OUT_W-1:0];
  endfunction

  assign adv       = !s2_vld_q || out_ready;
  assign in_ready  = rst_n && adv && (state_q == IDLE);
  assign out_valid = s2_vld_q;
  assign out_data  = s2_dat_q;
  assign busy      = (state_q != IDLE);

  // Lookup reads the registered table, so a same-edge write is seen one cycle later.
  always_comb begin
    s2_dat_d = '0;
    for (int k = 0; k < CH; k++) begin
      s2_dat_d[k*OUT_W +: OUT_W] = lut_q[s1_dat_q[k*IN_W +: IN_W]];
    end
  end

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    lut_we    = 1'b0;
    lut_waddr = cfg_addr;
    lut_wdat  = cfg_data;
    unique case (state_q)
      IDLE: begin
        lut_we = cfg_we;
        if (cfg_restore) state_d = DRAIN;
      end
      DRAIN: begin
        if (!s1_vld_q && !s2_vld_q) begin
          state_d = RESTORE;
          rcnt_d  = '0;
        end
      end
      RESTORE: begin
        lut_we    = 1'b1;
        lut_waddr = rcnt_q;
        lut_wdat  = def_val(rcnt_q);
        rcnt_d    = rcnt_q + 1'b1;
        if (rcnt_q == IN_W'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) lut_q[i] <= def_val(IN_W'(i));
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
    end else if (adv) begin
      s1_vld_q <= in_valid && (state_q == IDLE);
      if (in_valid && (state_q == IDLE)) s1_dat_q <= in_data;
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) s2_dat_q <= s2_dat_d;
    end
  end

endmodule

// File: tb/tb_conv_lut_bitsel_pipe.sv
// Directed bench for conv_lut_bitsel_pipe (IN_W=4, OUT_W=2, SHIFT=1, CH=4); honours CONV_LUT_SAT_EN.
module tb_conv_lut_bitsel_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [1:0]  cfg_data;
  logic        cfg_restore;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;

  int n_vec = 0;
  int n_bad = 0;

  conv_lut_bitsel_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_restore(cfg_restore), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Hand-written default table.
  function automatic logic [1:0] dflt(input logic [3:0] c);
    logic [1:0] r;
    case (c)
      4'd0, 4'd1:   r = 2'b00;
      4'd2, 4'd3:   r = 2'b01;
      4'd4, 4'd5:   r = 2'b10;
      4'd6, 4'd7:   r = 2'b11;
`ifdef CONV_LUT_SAT_EN
      default:      r = 2'b11;
`else
      4'd8, 4'd9:   r = 2'b00;
      4'd10, 4'd11: r = 2'b01;
      4'd12, 4'd13: r = 2'b10;
      default:      r = 2'b11;
`endif
    endcase
    return r;
  endfunction

  function automatic logic [7:0] dflt_beat(input logic [15:0] d);
    logic [7:0] r;
    for (int k = 0; k < 4; k++) r[k*2 +: 2] = dflt(d[k*4 +: 4]);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL reset_out_data got %h want 00", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_default_map();
    logic [15:0] beats [4];
    beats[0] = {4'd1, 4'd4, 4'd3, 4'd6};
    beats[1] = {4'd0, 4'd2, 4'd5, 4'd7};
    beats[2] = {4'd8, 4'd9, 4'd10, 4'd11};
    beats[3] = {4'd12, 4'd13, 4'd14, 4'd15};
    out_ready = 1'b1;
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) begin in_valid = 1'b1; in_data = beats[j]; end
      else in_valid = 1'b0;
      step();
      if (j >= 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== dflt_beat(beats[j-1])) begin
          n_bad++;
          $display("FAIL default_map beat %0d got v=%b d=%h want v=1 d=%h", j-1, out_valid, out_data, dflt_beat(beats[j-1]));
        end
      end
      if (j == 1) begin
        n_vec++;
        if (out_data !== 8'b00_10_01_11) begin n_bad++; $display("FAIL default_example got %b want 00100111", out_data); end
      end
    end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL default_map_idle got v=%b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    logic [1:0] e;
`ifdef CONV_LUT_SAT_EN
    e = 2'b11;
`else
    e = 2'b01;
`endif
    in_valid = 1'b1;
    in_data  = {4'b1010, 4'b1010, 4'b0100, 4'b1010};
    step();
    in_valid = 1'b0;
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== {e, e, 2'b10, e}) begin
      n_bad++; $display("FAIL saturation got v=%b d=%b want v=1 d=%b", out_valid, out_data, {e, e, 2'b10, e});
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [15:0] beats [8];
    logic [7:0]  held;
    logic        stall;
    int sent, got;
    sent = 0; got = 0; held = '0;
    for (int i = 0; i < 8; i++) beats[i] = {4'(i), 4'(i + 3), 4'(i + 7), 4'(15 - i)};
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      stall     = (cyc >= 4 && cyc < 7);
      out_ready = !stall;
      in_valid  = (sent < 8);
      in_data   = beats[(sent < 8) ? sent : 0];
      #1;
      if (stall && out_valid) begin
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc %0d got %b want 0", cyc, in_ready); end
        if (cyc > 4) begin
          n_vec++; if (out_data !== held) begin n_bad++; $display("FAIL bp_stable cyc %0d got %h want %h", cyc, out_data, held); end
        end
        held = out_data;
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (out_data !== dflt_beat(beats[got])) begin
          n_bad++; $display("FAIL bp_data beat %0d got %h want %h", got, out_data, dflt_beat(beats[got]));
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (got != 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", got); end
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup got v=%b want 0", out_valid); end
  endtask

  task automatic test_collision();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h6666;
    step();
    cfg_we = 1'b1; cfg_addr = 4'd6; cfg_data = 2'b00;
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hFF) begin n_bad++; $display("FAIL collision_old got v=%b d=%h want v=1 d=ff", out_valid, out_data); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'h00) begin n_bad++; $display("FAIL collision_new got v=%b d=%h want v=1 d=00", out_valid, out_data); end
    step();
  endtask

  task automatic test_restore();
    int cnt, rdy_hi;
    cnt = 0; rdy_hi = 0;
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 2'b10;
    step();
    cfg_we   = 1'b0;
    in_valid = 1'b1; in_data = 16'h3333;
    step();
    step();
    in_valid = 1'b0; cfg_restore = 1'b1;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin n_bad++; $display("FAIL restore_beat_a got v=%b d=%h want v=1 d=aa", out_valid, out_data); end
    step();
    cfg_restore = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin n_bad++; $display("FAIL restore_beat_b got v=%b d=%h want v=1 d=aa", out_valid, out_data); end
    while (busy === 1'b1 && cnt < 40) begin
      if (in_ready !== 1'b0) rdy_hi++;
      if (cnt == 5) begin
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_data = 2'b00; cfg_restore = 1'b1;
      end else begin
        cfg_we = 1'b0; cfg_restore = 1'b0;
      end
      cnt++;
      step();
    end
    cfg_we = 1'b0; cfg_restore = 1'b0;
    n_vec++; if (cnt != 18) begin n_bad++; $display("FAIL restore_busy_cycles got %0d want 18", cnt); end
    n_vec++; if (rdy_hi != 0) begin n_bad++; $display("FAIL restore_in_ready got %0d high cycles want 0", rdy_hi); end
    in_valid = 1'b1; in_data = {4'd2, 4'd6, 4'd3, 4'd3};
    step();
    in_valid = 1'b0;
    step();
    n_vec++; if (out_valid !== 1'b1 || out_data !== 8'b01_11_01_01) begin n_bad++; $display("FAIL restore_after got v=%b d=%b want v=1 d=01110101", out_valid, out_data); end
    step();
  endtask

  task automatic test_async_reset();
    logic [15:0] beats [4];
    beats[0] = {4'd3, 4'd2, 4'd1, 4'd0};
    beats[1] = {4'd7, 4'd6, 4'd5, 4'd4};
    beats[2] = {4'd11, 4'd10, 4'd9, 4'd8};
    beats[3] = {4'd15, 4'd14, 4'd13, 4'd12};
    out_ready = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd12; cfg_data = 2'b01;
    step();
    cfg_we = 1'b0; cfg_restore = 1'b1;
    step();
    cfg_restore = 1'b0;
    repeat (8) step();
    n_vec++; if (busy !== 1'b1) begin n_bad++; $display("FAIL arst_pre_busy got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int j = 0; j <= 4; j++) begin
      if (j < 4) begin in_valid = 1'b1; in_data = beats[j]; end
      else in_valid = 1'b0;
      step();
      if (j >= 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== dflt_beat(beats[j-1])) begin
          n_bad++;
          $display("FAIL arst_table beat %0d got v=%b d=%h want v=1 d=%h", j-1, out_valid, out_data, dflt_beat(beats[j-1]));
        end
      end
    end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy_after got %b want 0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_restore = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    test_reset();
    test_default_map();
    test_saturation();
    test_backpressure();
    test_collision();
    test_restore();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
